core_mem_port: RTL and testbench

Core-side requester for the shared-RAM arbiter: one instance per core turns a single load/store from the core into the arbiter's rden/wren/acq handshake, holds address and write data stable for the whole grant, captures read data after the RAM latency, and releases the bus. It sits between each core's datapath and its slice of the arbiter's `rden`/`wren`/`Address`/`Din`/`acq`/`Dq` buses. It is the initiator that the arbiter responds to.

---
 rtl/core_mem_port.sv | 118 +++++++++++
 tb/tb_core_mem_port.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_port.sv
// core_mem_port: per-core requester that turns one load/store into the shared-RAM arbiter handshake.
// Optional grant-wait timeout is enabled by defining CORE_MEM_PORT_TIMEOUT_EN.
module core_mem_port #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic              mem_acq,
    input  logic [DATA_W-1:0] mem_dq
);

`ifdef CORE_MEM_PORT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [3:0] LAT_LAST = 4'(RAM_LAT - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACCESS,
        RELEASE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [3:0]  lat_cnt;
    logic [7:0]  to_cnt;
    logic        to_hit;
    logic        lat_hit;

    assign to_hit  = TO_EN && (to_cnt == TO_LAST);
    assign lat_hit = (lat_cnt == LAT_LAST);

    // Strobes are decoded from state so an async reset removes them immediately.
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign mem_rden = ((state == REQ) || (state == ACCESS)) && !we_q;
    assign mem_wren = ((state == REQ) || (state == ACCESS)) && we_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = REQ;
            REQ: begin
                if (mem_acq)     state_next = ACCESS;
                else if (to_hit) state_next = RELEASE;
            end
            ACCESS:  if (!mem_acq || lat_hit) state_next = RELEASE;
            RELEASE: if (!mem_acq) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            lat_cnt  <= 4'd0;
            to_cnt   <= 8'd0;
            err      <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            rdata    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        mem_addr <= addr;
                        mem_din  <= wdata;
                        err      <= 1'b0;
                        to_cnt   <= 8'd0;
                    end
                end
                REQ: begin
                    lat_cnt <= 4'd0;
                    to_cnt  <= to_cnt + 8'd1;
                    if (!mem_acq && to_hit) err <= 1'b1;
                end
                ACCESS: begin
                    // A dropped grant abandons the access without touching rdata.
                    if (mem_acq) begin
                        if (lat_hit) begin
                            if (!we_q) rdata <= mem_dq;
                        end else begin
                            lat_cnt <= lat_cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_port.sv
// Directed testbench for core_mem_port with a small behavioural arbiter model.
module tb_core_mem_port;
    localparam int LAT = 3;
    localparam int TO  = 10;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       err;
    logic       mem_rden;
    logic       mem_wren;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_acq;
    logic [7:0] mem_dq;

    int checks = 0;
    int failures = 0;

    int grant_delay, hold_after, wait_cnt, hold_cnt, gcnt;
    bit never_grant;
    logic [7:0] dq_val;

    int rd_cycles, wr_cycles, done_cnt, first_done, second_done;
    int unstable, rises, rise2, first_fall;
    logic err_done, err_req, prev_rden;

    core_mem_port #(
        .ADDR_W(8), .DATA_W(8), .RAM_LAT(LAT), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_acq(mem_acq), .mem_dq(mem_dq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic arbReset();
        mem_acq  = 1'b0;
        mem_dq   = 8'hEE;
        wait_cnt = 0;
        hold_cnt = 0;
        gcnt     = 0;
    endtask

    // Arbiter model: grants after grant_delay request cycles, holds acq after release,
    // and presents dq_val only in the RAM_LAT-th cycle after the grant is sampled.
    task automatic arbStep();
        if (mem_rden || mem_wren) begin
            hold_cnt = 0;
            if (mem_acq) gcnt++;
            else begin
                wait_cnt++;
                if (!never_grant && wait_cnt > grant_delay) mem_acq = 1'b1;
            end
        end else begin
            wait_cnt = 0;
            gcnt     = 0;
            if (mem_acq) begin
                if (hold_cnt < hold_after) hold_cnt++;
                else mem_acq = 1'b0;
            end
        end
        mem_dq = (gcnt == LAT) ? dq_val : 8'hEE;
    endtask

    task automatic applyStimulus(input bit w, input logic [7:0] a, input logic [7:0] d,
                                 input logic [7:0] dqv, input int delay, input int hold,
                                 input bit ng, input bit hold_req);
        @(negedge clk);
        arbReset();
        grant_delay = delay; hold_after = hold; never_grant = ng; dq_val = dqv;
        req = 1'b1; we = w; addr = a; wdata = d;
        rd_cycles = 0; wr_cycles = 0; done_cnt = 0; first_done = 0; second_done = 0;
        unstable = 0; rises = 0; rise2 = 0; first_fall = 0; prev_rden = 1'b0;
        err_done = 1'b0; err_req = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (!hold_req) req = 1'b0;
            if (mem_rden && !prev_rden) begin
                rises++;
                if (rises == 2) begin
                    rise2 = i;
                    req   = 1'b0;
                end
            end
            if (!mem_rden && prev_rden && first_fall == 0) first_fall = i;
            prev_rden = mem_rden;
            if (mem_rden) rd_cycles++;
            if (mem_wren) wr_cycles++;
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
                else second_done = i;
                err_done = err;
            end
            if ((mem_rden || mem_wren) && (mem_addr !== a || mem_din !== d)) unstable++;
            if (i == 1) err_req = err;
            arbStep();
        end
        req = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
        never_grant = 1'b0; grant_delay = 0; hold_after = 0; dq_val = 8'h00;
        arbReset();
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_rden", mem_rden, 0);
        checkOutput("rst_wren", mem_wren, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_din", mem_din, 0);
        checkOutput("rst_rdata", rdata, 0);
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] load with immediate grant");
        applyStimulus(1'b0, 8'h12, 8'h00, 8'hA5, 0, 0, 1'b0, 1'b0);
        checkOutput("ld_rden_cycles", rd_cycles, 4);
        checkOutput("ld_wren_cycles", wr_cycles, 0);
        checkOutput("ld_done_cycle", first_done, 6);
        checkOutput("ld_done_count", done_cnt, 1);
        checkOutput("ld_rdata", rdata, 8'hA5);
        checkOutput("ld_err", err_done, 0);
        checkOutput("ld_stable", unstable, 0);

        $display("[TB] store with delayed grant");
        applyStimulus(1'b1, 8'h40, 8'h3C, 8'h99, 4, 0, 1'b0, 1'b0);
        checkOutput("st_wren_cycles", wr_cycles, 8);
        checkOutput("st_rden_cycles", rd_cycles, 0);
        checkOutput("st_done_cycle", first_done, 10);
        checkOutput("st_done_count", done_cnt, 1);
        checkOutput("st_rdata_kept", rdata, 8'hA5);
        checkOutput("st_stable", unstable, 0);

        $display("[TB] grant held after release");
        applyStimulus(1'b0, 8'h21, 8'h00, 8'h81, 0, 3, 1'b0, 1'b0);
        checkOutput("hold_rden_cycles", rd_cycles, 4);
        checkOutput("hold_done_cycle", first_done, 9);
        checkOutput("hold_rdata", rdata, 8'h81);

        $display("[TB] back-to-back loads");
        applyStimulus(1'b0, 8'h33, 8'h00, 8'h5A, 0, 0, 1'b0, 1'b1);
        checkOutput("b2b_done_count", done_cnt, 2);
        checkOutput("b2b_first_done", first_done, 6);
        checkOutput("b2b_second_done", second_done, 13);
        checkOutput("b2b_first_fall", first_fall, 5);
        checkOutput("b2b_second_rise", rise2, 8);
        checkOutput("b2b_rden_cycles", rd_cycles, 8);
        checkOutput("b2b_rdata", rdata, 8'h5A);

        $display("[TB] reset during access");
        @(negedge clk);
        arbReset();
        grant_delay = 0; hold_after = 0; never_grant = 1'b0; dq_val = 8'h33;
        req = 1'b1; we = 1'b0; addr = 8'h99; wdata = 8'h11;
        @(negedge clk);
        req = 1'b0;
        arbStep();
        @(negedge clk);
        arbStep();
        checkOutput("mid_rden_before", mem_rden, 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("mid_rden", mem_rden, 0);
        checkOutput("mid_wren", mem_wren, 0);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_addr", mem_addr, 0);
        checkOutput("mid_din", mem_din, 0);
        checkOutput("mid_rdata", rdata, 0);
        arbReset();
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(1'b0, 8'h55, 8'h00, 8'h77, 0, 0, 1'b0, 1'b0);
        checkOutput("post_rst_done_cycle", first_done, 6);
        checkOutput("post_rst_rdata", rdata, 8'h77);

`ifdef CORE_MEM_PORT_TIMEOUT_EN
        $display("[TB] grant timeout");
        applyStimulus(1'b0, 8'h66, 8'h00, 8'h44, 0, 0, 1'b1, 1'b0);
        checkOutput("to_rden_cycles", rd_cycles, TO);
        checkOutput("to_done_cycle", first_done, TO + 2);
        checkOutput("to_err", err_done, 1);
        checkOutput("to_rdata_kept", rdata, 8'h77);
        applyStimulus(1'b0, 8'h67, 8'h00, 8'h12, 0, 0, 1'b0, 1'b0);
        checkOutput("to_err_cleared", err_req, 0);
        checkOutput("to_recover_rdata", rdata, 8'h12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
